// File: rtl/mtimer.sv
// Machine timer / software-interrupt block: 64-bit mtime, mtimecmp, msip and a single-outstanding bus port.
// Optional tick prescaler enabled by defining MTIMER_PRESCALE_EN (divider set by PRESCALE_DIV).
module mtimer #(
    parameter int unsigned PRESCALE_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        timer_irq,
    output logic        sw_irq
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        access;
    logic        ready_d, ready_q;
    logic [2:0]  sel;
    logic        wr, rd;
    logic        wr_mtime;
    logic        tick;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus_addr[1:0];

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus_req) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        access  = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE:  access  = bus_req;
            S_ACK:   ready_d = 1'b1;
            default: ;
        endcase
    end

    assign sel      = bus_addr[4:2];
    assign wr       = access && bus_we;
    assign rd       = access && !bus_we;
    assign wr_mtime = wr && (sel == 3'd0 || sel == 3'd1);

    // ---------------- tick generation ----------------
`ifdef MTIMER_PRESCALE_EN
    logic [15:0] pre_q, pre_d;

    assign tick = (pre_q == 16'(PRESCALE_DIV - 1));

    always_comb begin
        pre_d = pre_q + 16'd1;
        if (wr_mtime || tick) pre_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    logic [15:0] unused_prescale;
    assign unused_prescale = 16'(PRESCALE_DIV);
    assign tick = 1'b1;
`endif

    // ---------------- register datapath ----------------
    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        hi_shadow_d = hi_shadow_q;
        rdata_d     = rdata_q;

        // A write to either mtime half replaces the increment for that cycle.
        if (wr) begin
            case (sel)
                3'd0:    mtime_d = {mtime_q[63:32], bus_wdata};
                3'd1:    mtime_d = {bus_wdata, mtime_q[31:0]};
                3'd2:    mtimecmp_d[31:0]  = bus_wdata;
                3'd3:    mtimecmp_d[63:32] = bus_wdata;
                3'd4:    msip_d = bus_wdata[0];
                default: ;
            endcase
        end

        if (rd) begin
            case (sel)
                3'd0: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                3'd1:    rdata_d = hi_shadow_q;
                3'd2:    rdata_d = mtimecmp_q[31:0];
                3'd3:    rdata_d = mtimecmp_q[63:32];
                3'd4:    rdata_d = {31'd0, msip_q};
                default: rdata_d = '0;
            endcase
        end

        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            hi_shadow_q <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            hi_shadow_q <= hi_shadow_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            irq_q       <= irq_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign timer_irq = irq_q;
    assign sw_irq    = msip_q;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: directed scenarios plus randomized bus traffic
// checked against a model that derives mtime arithmetically from the last write.
module tb_mtimer;

`ifdef MTIMER_PRESCALE_EN
    localparam int unsigned DIV = 8;
`else
    localparam int unsigned DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        timer_irq;
    logic        sw_irq;

    mtimer #(.PRESCALE_DIV(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .timer_irq (timer_irq),
        .sw_irq    (sw_irq)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; mtime after edge k is a pure function of k.
    longint unsigned cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [63:0]     m_base;
    longint unsigned m_bcyc;
    logic [63:0]     m_cmp;
    logic            m_msip;
    logic [31:0]     m_shadow;

    function automatic logic [63:0] mt_at(input longint unsigned k);
        return m_base + 64'((k - m_bcyc) / DIV);
    endfunction

    task automatic model_reset();
        m_base   = '0;
        m_bcyc   = 0;
        m_cmp    = '1;
        m_msip   = 1'b0;
        m_shadow = '0;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic xfer(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
        longint unsigned w;
        logic [63:0]     pre;
        logic [31:0]     exp_rd;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        @(posedge clk); #1;
        w      = cyc;
        pre    = mt_at(w - 1);
        exp_rd = '0;
        check_eq("ready_wait_state", bus_ready, 1'b0);
        if (we) begin
            case (addr[4:2])
                3'd0: begin m_base = {pre[63:32], wd}; m_bcyc = w; end
                3'd1: begin m_base = {wd, pre[31:0]};  m_bcyc = w; end
                3'd2: m_cmp[31:0]  = wd;
                3'd3: m_cmp[63:32] = wd;
                3'd4: m_msip = wd[0];
                default: ;
            endcase
        end else begin
            case (addr[4:2])
                3'd0: begin exp_rd = pre[31:0]; m_shadow = pre[63:32]; end
                3'd1: exp_rd = m_shadow;
                3'd2: exp_rd = m_cmp[31:0];
                3'd3: exp_rd = m_cmp[63:32];
                3'd4: exp_rd = {31'd0, m_msip};
                default: exp_rd = '0;
            endcase
        end
        @(posedge clk); #1;
        check_eq("ready_pulse", bus_ready, 1'b1);
        if (!we) check_eq("rdata", bus_rdata, exp_rd);
        check_eq("timer_irq", timer_irq, (mt_at(w) >= m_cmp));
        check_eq("sw_irq", sw_irq, m_msip);
        rd      = bus_rdata;
        bus_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ready", bus_ready, 1'b0);
            check_eq("idle_irq", timer_irq, (cyc >= 1) && (mt_at(cyc - 1) >= m_cmp));
        end
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 64));
            2:       return 32'hFFFF_FFFF;
            default: return 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
        endcase
    endfunction

    logic [31:0] r;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_rdata", bus_rdata, 32'd0);
        check_eq("rst_ready", bus_ready, 1'b0);
        check_eq("rst_timer_irq", timer_irq, 1'b0);
        check_eq("rst_sw_irq", sw_irq, 1'b0);
        reset = 1'b0;

        // Free-running count after reset, then low word read.
        idle(10);
        xfer(1'b0, 5'h00, '0, r);
        xfer(1'b0, 5'h04, '0, r);
        check_eq("hi_after_reset", r, 32'd0);

        // Carry from low into high word observed through the shadow.
        xfer(1'b1, 5'h00, 32'hFFFF_FFFE, r);
        xfer(1'b1, 5'h04, 32'h0, r);
        xfer(1'b0, 5'h00, '0, r);
        xfer(1'b0, 5'h04, '0, r);
        if (DIV == 1) check_eq("carry_hi", r, 32'd1);

        // Compare crossing and clearing.
        xfer(1'b1, 5'h04, 32'h0, r);
        xfer(1'b1, 5'h00, 32'h0, r);
        xfer(1'b1, 5'h0C, 32'h0, r);
        xfer(1'b1, 5'h08, 32'd20, r);
        idle(30 * DIV);
        xfer(1'b1, 5'h08, 32'hFFFF_FFFF, r);
        idle(3);

        // msip write/readback and unmapped offset.
        xfer(1'b1, 5'h10, 32'hFFFF_FFFF, r);
        xfer(1'b0, 5'h10, '0, r);
        xfer(1'b1, 5'h10, 32'h0, r);
        xfer(1'b0, 5'h18, '0, r);
        xfer(1'b1, 5'h1C, 32'hDEAD_BEEF, r);
        xfer(1'b0, 5'h1F, '0, r);

        // Restore mtimecmp high so the random phase starts quiet.
        xfer(1'b1, 5'h0C, 32'hFFFF_FFFF, r);
        for (int unsigned i = 0; i < 300; i++) begin
            xfer(1'($urandom_range(0, 1)), 5'($urandom), pick_data(), r);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        // Reset asserted while the bus is acknowledging.
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 5'h00;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_eq("rstack_ready", bus_ready, 1'b0);
        check_eq("rstack_rdata", bus_rdata, 32'd0);
        check_eq("rstack_irq", timer_irq, 1'b0);
        check_eq("rstack_sw", sw_irq, 1'b0);
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rstack_no_ready", bus_ready, 1'b0);
        end
        bus_req = 1'b0;
        model_reset();
        reset = 1'b0;
        xfer(1'b0, 5'h00, '0, r);
        xfer(1'b0, 5'h04, '0, r);
        xfer(1'b0, 5'h0C, '0, r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
